// File: rtl/gf_mult_seq_if.sv
// Handshake bundle for gf_mult_seq.
//   master : operand producer / result consumer (drives in_valid, x, y,
//            flush, out_ready; observes in_ready, out_valid, z, busy)
//   slave  : the multiplier itself
interface gf_mult_seq_if #(
  parameter int unsigned WIDTH = 128
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             busy;

  modport master (
    output in_valid,
    output x,
    output y,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  z,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  x,
    input  y,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output z,
    output busy
  );

endinterface

// File: rtl/gf_mult_seq.sv
// Digit-serial GF(2^WIDTH) multiplier with valid/ready handshakes.
// Right-shift / conditional-XOR-with-R algorithm, DIGIT bits of x per clock.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus.in_valid / bus.in_ready   : operand handshake, x and y captured on accept
//   bus.flush                     : synchronous abort, drops any pending result
//   bus.out_valid / bus.out_ready : result handshake, z held until taken
//   bus.busy                      : high while computing or holding a result
module gf_mult_seq #(
  parameter int unsigned      WIDTH    = 128,
  parameter int unsigned      DIGIT    = 8,
  parameter logic [WIDTH-1:0] R        = WIDTH'(128'h8700_0000_0000_0000_0000_0000_0000_0000),
  parameter bit               REVERSED = 1'b0
) (
  input logic         clk,
  input logic         rst_n,
  gf_mult_seq_if.slave bus
);

  localparam int unsigned STEPS = WIDTH / DIGIT;
  localparam int unsigned CW    = $clog2(STEPS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Reject digit sizes that do not tile the operand.
  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("gf_mult_seq: WIDTH must be a multiple of DIGIT");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] xr_q, xr_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q;
  logic             busy_q;

  logic [WIDTH-1:0] xr_step;
  logic [WIDTH-1:0] v_step;
  logic [WIDTH-1:0] acc_step;

  function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] a);
    return {<<{a}};
  endfunction

  // One clock's worth of work: DIGIT multiply-and-reduce steps, MSB of xr first.
  always_comb begin
    xr_step  = xr_q;
    v_step   = v_q;
    acc_step = acc_q;
    for (int j = 0; j < int'(DIGIT); j++) begin
      if (xr_step[WIDTH-1]) begin
        acc_step = acc_step ^ v_step;
      end
      v_step  = v_step[0] ? ((v_step >> 1) ^ R) : (v_step >> 1);
      xr_step = xr_step << 1;
    end
  end

  // Next-state and datapath update; flush overrides every handshake.
  always_comb begin
    state_d     = state_q;
    xr_d        = xr_q;
    v_d         = v_q;
    acc_d       = acc_q;
    count_d     = count_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;

    if (bus.flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      acc_d       = '0;
      count_d     = '0;
      z_d         = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            xr_d    = REVERSED ? bitrev(bus.x) : bus.x;
            v_d     = REVERSED ? bitrev(bus.y) : bus.y;
            acc_d   = '0;
            count_d = '0;
            state_d = BUSY;
          end
        end
        BUSY: begin
          xr_d    = xr_step;
          v_d     = v_step;
          acc_d   = acc_step;
          count_d = count_q + CW'(1);
          if (count_q == CW'(STEPS - 1)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            z_d         = REVERSED ? bitrev(acc_step) : acc_step;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; in_ready/busy are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      xr_q        <= '0;
      v_q         <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      xr_q        <= xr_d;
      v_q         <= v_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.z         = z_q;
  assign bus.busy      = busy_q;

  // A held result must not move or vanish until taken or flushed.
  a_hold_result: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !bus.out_ready && !bus.flush) |=> (out_valid_q && $stable(z_q)));

  // Accepting operands and being busy are mutually exclusive.
  a_ready_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (in_ready_q != busy_q));

  // A valid result only exists while the block reports busy.
  a_valid_busy: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q |-> busy_q));

endmodule

// File: tb/tb_gf_mult_seq.sv
// Bench for gf_mult_seq: seven parameter variants share one stimulus stream;
// a protocol/arith reference model is compared against every instance each cycle.
module tb_gf_mult_seq;

  localparam int unsigned W  = 128;
  localparam int unsigned NI = 7;
  localparam logic [W-1:0] RC   = 128'h8700_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [W-1:0] ONE  = 128'h0000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [W-1:0] XMSB = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [W-1:0] X1   = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [W-1:0] X2   = 128'h2000_0000_0000_0000_0000_0000_0000_0000;
  localparam logic [W-1:0] YPAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [W-1:0] RSH1 = 128'h4380_0000_0000_0000_0000_0000_0000_0000;

  function automatic int unsigned dig_of(input int unsigned i);
    case (i)
      0: return 8;
      1: return 1;
      2: return 4;
      3: return 16;
      4: return 32;
      5: return 128;
      default: return 8;
    endcase
  endfunction

  function automatic bit rev_of(input int unsigned i);
    return (i == 1) || (i == 3) || (i == 5) || (i == 6);
  endfunction

  logic           clk     = 1'b0;
  logic           rst_n   = 1'b1;
  logic           s_valid = 1'b0;
  logic           s_flush = 1'b0;
  logic           s_ordy  = 1'b1;
  logic [W-1:0]   s_x     = '0;
  logic [W-1:0]   s_y     = '0;

  logic           ov [NI];
  logic           ir [NI];
  logic           bz [NI];
  logic [W-1:0]   zz [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    gf_mult_seq_if #(.WIDTH(W)) bus_i ();
    assign bus_i.in_valid  = s_valid;
    assign bus_i.x         = s_x;
    assign bus_i.y         = s_y;
    assign bus_i.flush     = s_flush;
    assign bus_i.out_ready = s_ordy;
    assign ov[g] = bus_i.out_valid;
    assign ir[g] = bus_i.in_ready;
    assign bz[g] = bus_i.busy;
    assign zz[g] = bus_i.z;

    gf_mult_seq #(
      .WIDTH    (W),
      .DIGIT    (dig_of(g)),
      .R        (RC),
      .REVERSED (rev_of(g))
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_i)
    );
  end

  // Reference: polynomial product in the reflected domain, then reduction
  // modulo x^W + reflect(R).
  function automatic logic [W-1:0] brev(input logic [W-1:0] a);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) r[i] = a[int'(W) - 1 - i];
    return r;
  endfunction

  function automatic logic [W-1:0] gf_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input bit rev);
    logic [2*W-1:0] p;
    logic [2*W-1:0] m;
    logic [W-1:0]   pa, pb, r;
    pa = rev ? a : brev(a);
    pb = rev ? b : brev(b);
    p  = '0;
    for (int k = 0; k < int'(W); k++)
      if (pa[k]) p = p ^ ({{W{1'b0}}, pb} << k);
    m = {{(W-1){1'b0}}, 1'b1, brev(RC)};
    for (int k = 2*int'(W) - 2; k >= int'(W); k--)
      if (p[k]) p = p ^ (m << (k - int'(W)));
    r = p[W-1:0];
    return rev ? r : brev(r);
  endfunction

  int checks = 0;
  int errors = 0;
  int tmo_cnt = 0;
  int tmo_seen = 0;
  bit pinned = 1'b0;

  int           m_ph   [NI];   // 0 idle, 1 computing, 2 holding result
  int           m_left [NI];
  logic [W-1:0] m_res  [NI];
  logic [W-1:0] m_z    [NI];

  function automatic void chk(input bit ok, input string nm, input int idx,
                              input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s inst%0d: got %h, expected %h", nm, idx, act, exp);
    end
  endfunction

  // Single compare process: sample at negedge, then advance the model to the next posedge.
  always @(negedge clk) begin
    logic [W-1:0] r;
    if (!pinned) begin
      pinned = 1'b1;
      r = gf_ref(XMSB, YPAT, 1'b0); chk(r == YPAT, "model_unit", -1, r, YPAT);
      r = gf_ref(X1, ONE, 1'b0);    chk(r == RC,   "model_reduce", -1, r, RC);
      r = gf_ref(X2, ONE, 1'b0);    chk(r == RSH1, "model_reduce2", -1, r, RSH1);
      r = gf_ref('0, YPAT, 1'b0);   chk(r == '0,   "model_zero", -1, r, '0);
      r = gf_ref(ONE, YPAT, 1'b1);  chk(r == YPAT, "model_rev_unit", -1, r, YPAT);
    end
    chk(tmo_cnt == tmo_seen, "wait_bound", -1, W'(tmo_cnt), W'(tmo_seen));
    tmo_seen = tmo_cnt;
    for (int i = 0; i < int'(NI); i++) begin
      if (!rst_n) begin
        chk(ir[i] == 1'b1, "rst_in_ready", i, W'(ir[i]), W'(1));
        chk(ov[i] == 1'b0, "rst_out_valid", i, W'(ov[i]), W'(0));
        chk(bz[i] == 1'b0, "rst_busy", i, W'(bz[i]), W'(0));
        chk(zz[i] == '0,   "rst_z", i, zz[i], '0);
        m_ph[i] = 0;
        m_z[i]  = '0;
      end else begin
        chk(ir[i] == (m_ph[i] == 0), "in_ready", i, W'(ir[i]), W'(m_ph[i] == 0));
        chk(ov[i] == (m_ph[i] == 2), "out_valid", i, W'(ov[i]), W'(m_ph[i] == 2));
        chk(bz[i] == (m_ph[i] != 0), "busy", i, W'(bz[i]), W'(m_ph[i] != 0));
        chk(zz[i] == m_z[i], "z", i, zz[i], m_z[i]);
        if (s_flush) begin
          m_ph[i] = 0;
          m_z[i]  = '0;
        end else begin
          case (m_ph[i])
            0: if (s_valid) begin
                 m_ph[i]   = 1;
                 m_left[i] = int'(W / dig_of(i));
                 m_res[i]  = gf_ref(s_x, s_y, rev_of(i));
               end
            1: begin
                 m_left[i]--;
                 if (m_left[i] == 0) begin
                   m_ph[i] = 2;
                   m_z[i]  = m_res[i];
                 end
               end
            default: if (s_ordy) m_ph[i] = 0;
          endcase
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b);
    s_x = a;
    s_y = b;
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < int'(NI); i++) if (!ir[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_all_idle(input int bound);
    int n = 0;
    while (!all_idle() && n < bound) begin tick(); n++; end
    if (!all_idle()) tmo_cnt++;
  endtask

  task automatic wait_main_ov(input int bound);
    int n = 0;
    while (!ov[0] && n < bound) begin tick(); n++; end
    if (!ov[0]) tmo_cnt++;
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #2 rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Unit multiplier, single reduction, reversed-unit operand.
    offer(XMSB, YPAT);
    wait_all_idle(300);
    offer(X1, ONE);
    wait_all_idle(300);
    offer(ONE, YPAT);
    wait_all_idle(300);

    // Zero product held under back-pressure.
    s_ordy = 1'b0;
    offer('0, rnd());
    wait_main_ov(40);
    repeat (5) tick();
    s_ordy = 1'b1;
    wait_all_idle(300);

    // Operands offered while busy are ignored; flush at count 7 with in_valid.
    offer(rnd(), rnd());
    offer(rnd(), rnd());
    repeat (6) tick();
    s_x = rnd();
    s_y = rnd();
    s_valid = 1'b1;
    s_flush = 1'b1;
    tick();
    s_flush = 1'b0;
    s_valid = 1'b0;
    tick();
    wait_all_idle(300);
    offer(rnd(), rnd());
    wait_all_idle(300);

    // Asynchronous reset mid-computation.
    offer(rnd(), rnd());
    repeat (3) tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    wait_all_idle(300);

    // Asynchronous reset while holding a result.
    s_ordy = 1'b0;
    offer(rnd(), rnd());
    wait_main_ov(40);
    tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    s_ordy = 1'b1;
    tick();
    wait_all_idle(300);

    // Random operands across all variants.
    for (int t = 0; t < 250; t++) begin
      offer(rnd(), rnd());
      wait_all_idle(300);
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
